// File: rtl/hdlc_line_monitor.sv
// hdlc_line_monitor
//   Passive HDLC line checker running beside the Rx path. Each of CHANNELS
//   serial lines gets its own flag / abort / idle detector, zero-bit
//   destuffer, LSB-first byte reassembler and frame classifier, plus
//   saturating good / errored / aborted frame counters.
//
// Ports
//   Clk, Rst        clock, asynchronous active-high reset
//   En[c], Rx[c]    bit strobe and serial data of channel c
//   ClrCnt          synchronous clear of every statistics counter
//   Sel             channel whose counters drive FrameCnt/ErrCnt/AbortCnt
//   FlagDet, AbortDet, ByteValid, FrameEnd, FrameError, FrameAbort
//                   per-channel one-cycle pulses (registered)
//   Idle            per-channel level, line has been all ones for IDLE_LEN bits
//   ByteData        reassembled bytes, channel c in [8c+7:8c], held between bytes
//   FrameCnt, ErrCnt, AbortCnt  counters of the selected channel
module hdlc_line_monitor #(
    parameter int CHANNELS  = 1,
    parameter int CNT_W     = 16,
    parameter int MAX_BYTES = 128,
    parameter int MIN_BYTES = 4,
    parameter int IDLE_LEN  = 8,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [CHANNELS-1:0]   En,
    input  logic [CHANNELS-1:0]   Rx,
    input  logic                  ClrCnt,
    input  logic [SEL_W-1:0]      Sel,
    output logic [CHANNELS-1:0]   FlagDet,
    output logic [CHANNELS-1:0]   AbortDet,
    output logic [CHANNELS-1:0]   Idle,
    output logic [CHANNELS-1:0]   ByteValid,
    output logic [8*CHANNELS-1:0] ByteData,
    output logic [CHANNELS-1:0]   FrameEnd,
    output logic [CHANNELS-1:0]   FrameError,
    output logic [CHANNELS-1:0]   FrameAbort,
    output logic [CNT_W-1:0]      FrameCnt,
    output logic [CNT_W-1:0]      ErrCnt,
    output logic [CNT_W-1:0]      AbortCnt
);

    localparam int ONES_W  = $clog2(IDLE_LEN + 1);
    // Bit count at which byte MAX_BYTES+1 would be emitted: the frame is oversize.
    localparam int OVF_CNT = 8 * (MAX_BYTES + 1) + 7;
    localparam int DCNT_W  = $clog2(OVF_CNT + 1);
    // Smallest bit count at a closing flag that still holds MIN_BYTES bytes.
    localparam int MIN_CNT = 8 * MIN_BYTES + 7;

    typedef enum logic [1:0] {HUNT, OPEN, DATA, DROP} state_t;

    function automatic logic [CNT_W-1:0] cntNext(input logic [CNT_W-1:0] cur,
                                                 input logic inc, input logic clr);
        if (clr)
            return inc ? CNT_W'(1) : '0;
        if (inc && (cur != '1))
            return cur + CNT_W'(1);
        return cur;
    endfunction

    logic [CNT_W-1:0] frameArr [CHANNELS];
    logic [CNT_W-1:0] errArr   [CHANNELS];
    logic [CNT_W-1:0] abortArr [CHANNELS];

    for (genvar c = 0; c < CHANNELS; c++) begin : gCh
        state_t            state;
        logic [ONES_W-1:0] ones, onesNext;
        logic              lead0;        // a 0 has been seen since reset
        logic [13:0]       dReg;         // last 14 data bits; with the new bit forms the 15-bit lag
        logic [14:0]       dRegNext;
        logic [DCNT_W-1:0] dcnt, dcntNext;
        logic              isStuff, isFlag, isAbort, isData, emitHit;
        logic              emit, ovf, incFrame, incErr, incAbort;
        logic              flagDet_p1, abortDet_p1, idle_p1, vld_p1;
        logic              frameEnd_p1, frameErr_p1, frameAbort_p1;
        logic [7:0]        byteData_p1;
        logic [CNT_W-1:0]  frameCnt, errCnt, abortCnt;

        always_comb begin
            onesNext = Rx[c] ? ((ones == ONES_W'(IDLE_LEN)) ? ones : ones + ONES_W'(1)) : '0;
            isStuff  = !Rx[c] && (ones == ONES_W'(5));
            // lead0 only changes on a 0, so it tells whether the bit before this run was 0.
            isFlag   = !Rx[c] && (ones == ONES_W'(6)) && lead0;
            isAbort  = Rx[c] && (ones == ONES_W'(6));
            isData   = !isStuff && !isFlag;
            dRegNext = {Rx[c], dReg};
            dcntNext = dcnt + DCNT_W'(1);
            emitHit  = (dcntNext[2:0] == 3'd7) && (dcntNext >= DCNT_W'(15));
            emit     = 1'b0;
            ovf      = 1'b0;
            incFrame = 1'b0;
            incErr   = 1'b0;
            incAbort = 1'b0;
            if (En[c]) begin
                if ((state == DATA) && isData && emitHit) begin
                    if (dcntNext == DCNT_W'(OVF_CNT))
                        ovf = 1'b1;
                    else
                        emit = 1'b1;
                end
                if (isAbort) begin
                    incAbort = (state == DATA) || (state == DROP);
                end else if (isFlag && (state == DATA) && (dcnt != DCNT_W'(7))) begin
                    // dcnt still carries the seven flag bits that entered the delay line.
                    if ((dcnt[2:0] == 3'd7) && (dcnt >= DCNT_W'(MIN_CNT)))
                        incFrame = 1'b1;
                    else
                        incErr = 1'b1;
                end else if (ovf) begin
                    incErr = 1'b1;
                end
            end
        end

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                state         <= HUNT;
                ones          <= '0;
                lead0         <= 1'b0;
                dReg          <= '0;
                dcnt          <= '0;
                flagDet_p1    <= 1'b0;
                abortDet_p1   <= 1'b0;
                idle_p1       <= 1'b0;
                vld_p1        <= 1'b0;
                frameEnd_p1   <= 1'b0;
                frameErr_p1   <= 1'b0;
                frameAbort_p1 <= 1'b0;
                byteData_p1   <= '0;
                frameCnt      <= '0;
                errCnt        <= '0;
                abortCnt      <= '0;
            end else begin
                frameCnt      <= cntNext(frameCnt, incFrame, ClrCnt);
                errCnt        <= cntNext(errCnt, incErr, ClrCnt);
                abortCnt      <= cntNext(abortCnt, incAbort, ClrCnt);
                flagDet_p1    <= En[c] && isFlag;
                abortDet_p1   <= En[c] && isAbort;
                vld_p1        <= emit;
                frameEnd_p1   <= incFrame;
                frameErr_p1   <= incErr;
                frameAbort_p1 <= incAbort;
                if (emit)
                    byteData_p1 <= dRegNext[7:0];
                if (En[c]) begin
                    ones    <= onesNext;
                    idle_p1 <= (onesNext >= ONES_W'(IDLE_LEN));
                    if (!Rx[c])
                        lead0 <= 1'b1;
                    if (isAbort) begin
                        state <= HUNT;
                        dcnt  <= '0;
                    end else if (isFlag) begin
                        state <= OPEN;
                        dcnt  <= '0;
                    end else if (isData) begin
                        case (state)
                            OPEN: begin
                                state <= DATA;
                                dReg  <= dRegNext[14:1];
                                dcnt  <= dcntNext;
                            end
                            DATA: begin
                                dReg <= dRegNext[14:1];
                                dcnt <= dcntNext;
                                if (ovf)
                                    state <= DROP;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end

        assign FlagDet[c]         = flagDet_p1;
        assign AbortDet[c]        = abortDet_p1;
        assign Idle[c]            = idle_p1;
        assign ByteValid[c]       = vld_p1;
        assign ByteData[8*c +: 8] = byteData_p1;
        assign FrameEnd[c]        = frameEnd_p1;
        assign FrameError[c]      = frameErr_p1;
        assign FrameAbort[c]      = frameAbort_p1;
        assign frameArr[c]        = frameCnt;
        assign errArr[c]          = errCnt;
        assign abortArr[c]        = abortCnt;
    end

    // Readout mux; an out-of-range Sel reads zero.
    always_comb begin
        FrameCnt = '0;
        ErrCnt   = '0;
        AbortCnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (Sel == SEL_W'(i)) begin
                FrameCnt = frameArr[i];
                ErrCnt   = errArr[i];
                AbortCnt = abortArr[i];
            end
        end
    end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// tb_hdlc_line_monitor
//   Directed bench for hdlc_line_monitor. dut1 is a single-channel instance
//   (MAX_BYTES=128, MIN_BYTES=4, IDLE_LEN=8); dut2 has two channels with
//   channel 1 strobed every third cycle. Frames are built by a small HDLC
//   transmitter model (flags + zero stuffing) and played bit by bit.
module tb_hdlc_line_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [0:0]  en1, rx1, sel1;
    logic        clr1;
    logic [0:0]  flag1, abort1, idle1, bv1, fe1, ferr1, fab1;
    logic [7:0]  bd1;
    logic [15:0] fcnt1, ecnt1, acnt1;

    logic [1:0]  en2, rx2;
    logic [0:0]  sel2;
    logic        clr2;
    logic [1:0]  flag2, abort2, idle2, bv2, fe2, ferr2, fab2;
    logic [15:0] bd2;
    logic [15:0] fcnt2, ecnt2, acnt2;

    hdlc_line_monitor #(.CHANNELS(1), .CNT_W(16), .MAX_BYTES(128), .MIN_BYTES(4), .IDLE_LEN(8)) dut1 (
        .Clk(clk), .Rst(rst), .En(en1), .Rx(rx1), .ClrCnt(clr1), .Sel(sel1),
        .FlagDet(flag1), .AbortDet(abort1), .Idle(idle1), .ByteValid(bv1), .ByteData(bd1),
        .FrameEnd(fe1), .FrameError(ferr1), .FrameAbort(fab1),
        .FrameCnt(fcnt1), .ErrCnt(ecnt1), .AbortCnt(acnt1));

    hdlc_line_monitor #(.CHANNELS(2), .CNT_W(16), .MAX_BYTES(128), .MIN_BYTES(4), .IDLE_LEN(8)) dut2 (
        .Clk(clk), .Rst(rst), .En(en2), .Rx(rx2), .ClrCnt(clr2), .Sel(sel2),
        .FlagDet(flag2), .AbortDet(abort2), .Idle(idle2), .ByteValid(bv2), .ByteData(bd2),
        .FrameEnd(fe2), .FrameError(ferr2), .FrameAbort(fab2),
        .FrameCnt(fcnt2), .ErrCnt(ecnt2), .AbortCnt(acnt2));

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Transmitter model
    logic txq[$];
    int   txOnes = 0;

    task automatic putRaw(input logic b);
        txq.push_back(b);
    endtask

    task automatic putFlag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) putRaw(f[i]);
        txOnes = 0;
    endtask

    task automatic putData(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            putRaw(w[i]);
            if (w[i]) begin
                txOnes++;
                if (txOnes == 5) begin
                    putRaw(1'b0);
                    txOnes = 0;
                end
            end else begin
                txOnes = 0;
            end
        end
    endtask

    // dut1 event tallies
    int nFlag1 = 0, nAbort1 = 0, nEnd1 = 0, nErr1 = 0, nFab1 = 0;
    int endNoFlag1 = 0, errNoFlag1 = 0, fabNoAbort1 = 0;
    logic [7:0] bq1[$];

    task automatic step1(input logic b);
        rx1[0] = b;
        en1[0] = 1'b1;
        @(posedge clk);
        #1;
        if (flag1[0])  nFlag1++;
        if (abort1[0]) nAbort1++;
        if (fe1[0])    nEnd1++;
        if (ferr1[0])  nErr1++;
        if (fab1[0])   nFab1++;
        if (fe1[0] && !flag1[0])   endNoFlag1++;
        if (ferr1[0] && !flag1[0]) errNoFlag1++;
        if (fab1[0] && !abort1[0]) fabNoAbort1++;
        if (bv1[0]) bq1.push_back(bd1);
    endtask

    task automatic play1();
        while (txq.size() > 0) step1(txq.pop_front());
    endtask

    function automatic logic [31:0] first4();
        logic [31:0] g;
        g = '0;
        for (int i = 0; i < bq1.size() && i < 4; i++) g[8*i +: 8] = bq1[i];
        return g;
    endfunction

    typedef struct {
        logic [63:0] data;
        int          nBits;
        int          expBytes;
        logic [31:0] expFirst4;
        int          expEnd;
        int          expErr;
    } vec_t;
    vec_t vecs[6];

    // dut2 tallies
    logic q0[$], q1[$];
    int nEnd2[2], nBad2[2], nBv2[2];
    logic [31:0] bw2[2];
    int gateBad = 0;
    int len, cyc, e0, r0, f0, a0;
    logic prevEn1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 64'h810FFFA5,   nBits: 32, expBytes: 4, expFirst4: 32'h810FFFA5, expEnd: 1, expErr: 0};
        vecs[1] = '{data: 64'hABC,        nBits: 12, expBytes: 1, expFirst4: 32'h000000BC, expEnd: 0, expErr: 1};
        vecs[2] = '{data: 64'h12345678,   nBits: 32, expBytes: 4, expFirst4: 32'h12345678, expEnd: 1, expErr: 0};
        vecs[3] = '{data: 64'h332211,     nBits: 24, expBytes: 3, expFirst4: 32'h00332211, expEnd: 0, expErr: 1};
        vecs[4] = '{data: 64'h3C00FF7E7E, nBits: 40, expBytes: 5, expFirst4: 32'h00FF7E7E, expEnd: 1, expErr: 0};
        vecs[5] = '{data: 64'h0,          nBits: 0,  expBytes: 0, expFirst4: 32'h00000000, expEnd: 0, expErr: 0};

        rst = 1'b1; en1 = '0; rx1 = '0; clr1 = 1'b0; sel1 = '0;
        en2 = '0; rx2 = '0; clr2 = 1'b0; sel2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_flag", flag1, 0);
        check("rst_idle", idle1, 0);
        check("rst_bytedata", bd1, 0);
        check("rst_framecnt", fcnt1, 0);
        check("rst_errcnt", ecnt1, 0);
        check("rst_abortcnt", acnt1, 0);
        check("rst_bytedata2", bd2, 0);

        // Idle line: ten ones
        for (int i = 1; i <= 10; i++) begin
            step1(1'b1);
            check($sformatf("idle_abortdet_bit%0d", i), abort1, (i == 7));
            check($sformatf("idle_level_bit%0d", i), idle1, (i >= 8));
        end
        check("idle_no_flag", nFlag1, 0);
        check("idle_no_frameabort", nFab1, 0);
        check("idle_framecnt", fcnt1, 0);
        check("idle_abortcnt", acnt1, 0);

        // Frame table
        for (int v = 0; v < 6; v++) begin
            bq1.delete();
            e0 = nEnd1;
            r0 = nErr1;
            putFlag();
            putData(vecs[v].data, vecs[v].nBits);
            putFlag();
            play1();
            check($sformatf("vec%0d_nbytes", v), bq1.size(), vecs[v].expBytes);
            check($sformatf("vec%0d_bytes", v), first4(), vecs[v].expFirst4);
            check($sformatf("vec%0d_closeflag", v), flag1, 1);
            check($sformatf("vec%0d_frameend_now", v), fe1, vecs[v].expEnd);
            check($sformatf("vec%0d_frameerr_now", v), ferr1, vecs[v].expErr);
            check($sformatf("vec%0d_end_count", v), nEnd1 - e0, vecs[v].expEnd);
            check($sformatf("vec%0d_err_count", v), nErr1 - r0, vecs[v].expErr);
        end
        check("table_framecnt", fcnt1, 3);
        check("table_errcnt", ecnt1, 2);
        check("table_abortcnt", acnt1, 0);
        check("table_end_with_flag", endNoFlag1, 0);
        check("table_err_with_flag", errNoFlag1, 0);

        // Abort mid-frame
        bq1.delete();
        f0 = nFab1;
        a0 = nAbort1;
        putFlag();
        putData(64'h3412, 16);
        for (int i = 0; i < 7; i++) putRaw(1'b1);
        play1();
        check("abort_abortdet_now", abort1, 1);
        check("abort_frameabort_now", fab1, 1);
        check("abort_fab_count", nFab1 - f0, 1);
        check("abort_det_count", nAbort1 - a0, 1);
        check("abort_fab_with_det", fabNoAbort1, 0);
        check("abort_nbytes", bq1.size(), 2);
        check("abort_bytes", first4(), 32'h00003412);
        check("abort_abortcnt", acnt1, 1);
        // Back in HUNT: unflagged zeros must not assemble bytes
        bq1.delete();
        for (int i = 0; i < 24; i++) putRaw(1'b0);
        play1();
        check("hunt_no_bytes", bq1.size(), 0);
        e0 = nEnd1;
        putFlag();
        putData(64'h810FFFA5, 32);
        putFlag();
        play1();
        check("after_abort_end", nEnd1 - e0, 1);
        check("after_abort_framecnt", fcnt1, 4);

        // Oversize frame: 129 bytes
        bq1.delete();
        e0 = nEnd1;
        r0 = nErr1;
        f0 = errNoFlag1;
        putFlag();
        for (int i = 0; i < 129; i++) putData(64'h55, 8);
        putFlag();
        play1();
        check("ovs_nbytes", bq1.size(), 128);
        check("ovs_err_count", nErr1 - r0, 1);
        check("ovs_err_before_flag", errNoFlag1 - f0, 1);
        check("ovs_no_end", nEnd1 - e0, 0);
        check("ovs_closeflag", flag1, 1);
        check("ovs_closeflag_no_err", ferr1, 0);
        check("ovs_errcnt", ecnt1, 3);
        check("ovs_framecnt", fcnt1, 4);

        // Multichannel
        txq.delete();
        txOnes = 0;
        putFlag();
        putData(64'h810FFFA5, 32);
        putFlag();
        q1 = txq;
        len = q1.size();
        for (int k = 0; k < (3 * len) / 8 + 2; k++) putFlag();
        q0 = txq;
        txq.delete();
        for (int c = 0; c < 2; c++) begin
            nEnd2[c] = 0; nBad2[c] = 0; nBv2[c] = 0; bw2[c] = '0;
        end
        cyc = 0;
        while (q1.size() > 0 && cyc < 2000) begin
            en2[0] = 1'b1;
            rx2[0] = (q0.size() > 0) ? q0.pop_front() : 1'b0;
            en2[1] = (cyc % 3 == 0);
            clr2   = 1'b0;
            if (en2[1]) begin
                rx2[1] = q1.pop_front();
                clr2   = (q1.size() == 0);
            end else begin
                rx2[1] = 1'($urandom_range(1));
            end
            prevEn1 = en2[1];
            @(posedge clk);
            #1;
            for (int c = 0; c < 2; c++) begin
                if (fe2[c]) nEnd2[c]++;
                if (ferr2[c] || fab2[c]) nBad2[c]++;
                if (bv2[c]) begin
                    if (nBv2[c] < 4) bw2[c][8*nBv2[c] +: 8] = bd2[8*c +: 8];
                    nBv2[c]++;
                end
            end
            if (!prevEn1 && (flag2[1] || abort2[1] || bv2[1] || fe2[1] || ferr2[1] || fab2[1]))
                gateBad++;
            if (cyc == 2 * len) begin
                sel2 = 1'b0;
                #1;
                check("mc_mid_sel0_framecnt", fcnt2, 1);
                sel2 = 1'b1;
                #1;
                check("mc_mid_sel1_framecnt", fcnt2, 0);
                check("mc_mid_ch1_no_end", nEnd2[1], 0);
            end
            cyc++;
        end
        check("mc_ch1_frameend_now", fe2[1], 1);
        check("mc_ch1_flag_now", flag2[1], 1);
        en2 = '0;
        clr2 = 1'b0;
        @(posedge clk);
        #1;
        sel2 = 1'b1;
        #1;
        check("mc_sel1_framecnt_clr", fcnt2, 1);
        check("mc_sel1_errcnt", ecnt2, 0);
        check("mc_sel1_abortcnt", acnt2, 0);
        sel2 = 1'b0;
        #1;
        check("mc_sel0_framecnt_cleared", fcnt2, 0);
        check("mc_ch0_end", nEnd2[0], 1);
        check("mc_ch1_end", nEnd2[1], 1);
        check("mc_ch0_bad", nBad2[0], 0);
        check("mc_ch1_bad", nBad2[1], 0);
        check("mc_ch0_nbytes", nBv2[0], 4);
        check("mc_ch1_nbytes", nBv2[1], 4);
        check("mc_ch0_bytes", bw2[0], 32'h810FFFA5);
        check("mc_ch1_bytes", bw2[1], 32'h810FFFA5);
        check("mc_ch1_gated", gateBad, 0);
        check("mc_bytedata_hold", bd2, 16'h8181);

        // Reset mid-frame on dut1
        putFlag();
        putData(64'h3412, 16);
        play1();
        en1 = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_no_abort", fab1, 0);
        check("rstmid_no_err", ferr1, 0);
        check("rstmid_errcnt", ecnt1, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_after_no_err", ferr1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
